// File: rtl/stopwatch_ctrl_if.sv
// Command/status bundle between the stopwatch sequencer and its controller.
// Signal names match the board-level names used by the display chain.
interface stopwatch_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  Start;
  logic                  Stop;
  logic                  Clear;
  logic                  Down;
  logic [4*DIGITS-1:0]   Load;
  logic [4*DIGITS-1:0]   Digits;
  logic                  Tick;
  logic                  Running;
  logic                  Done;
  logic [1:0]            State;

  modport master (
    output Start, Stop, Clear, Down, Load,
    input  Digits, Tick, Running, Done, State
  );

  modport slave (
    input  Start, Stop, Clear, Down, Load,
    output Digits, Tick, Running, Done, State
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch / countdown sequencer: 1 Hz prescaler, DIGITS-wide BCD counter
// and a 4-state start/stop/clear FSM.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 50000000,
  parameter int DIGITS   = 4
) (
  input  logic             CLOCK_50,
  input  logic             Reset,
  stopwatch_ctrl_if.slave  sw
);
  localparam int W  = 4 * DIGITS;
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic [PW-1:0]   presc_reg, presc_next;
  logic [W-1:0]    digits_reg, digits_next;
  logic            dir_reg, dir_next;
  logic            tick_reg, tick_next;

  logic [W-1:0]    load_clamped;
  logic [W-1:0]    inc_val;
  logic [W-1:0]    dec_val;
  logic [DIGITS-1:0] carry;
  logic [DIGITS-1:0] borrow;

  assign carry[0]  = 1'b1;
  assign borrow[0] = 1'b1;

  // Per-digit clamp, ripple-carry increment and ripple-borrow decrement.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] ld;
      logic [3:0] cur;
      assign ld  = sw.Load[gi*4 +: 4];
      assign cur = digits_reg[gi*4 +: 4];
      assign load_clamped[gi*4 +: 4] = (ld > 4'd9) ? 4'd9 : ld;
      assign inc_val[gi*4 +: 4] = !carry[gi]  ? cur :
                                  (cur == 4'd9) ? 4'd0 : cur + 4'd1;
      assign dec_val[gi*4 +: 4] = !borrow[gi] ? cur :
                                  (cur == 4'd0) ? 4'd9 : cur - 4'd1;
      if (gi < DIGITS - 1) begin : g_chain
        assign carry[gi+1]  = carry[gi]  && (cur == 4'd9);
        assign borrow[gi+1] = borrow[gi] && (cur == 4'd0);
      end
    end
  endgenerate

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      state_reg  <= IDLE;
      presc_reg  <= '0;
      digits_reg <= '0;
      dir_reg    <= 1'b0;
      tick_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      presc_reg  <= presc_next;
      digits_reg <= digits_next;
      dir_reg    <= dir_next;
      tick_reg   <= tick_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    presc_next  = presc_reg;
    digits_next = digits_reg;
    dir_next    = dir_reg;
    tick_next   = 1'b0;

    if (sw.Clear) begin
      state_next  = IDLE;
      presc_next  = '0;
      digits_next = '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (sw.Start) begin
            dir_next   = sw.Down;
            presc_next = '0;
            state_next = RUN;
            if (sw.Down) begin
              digits_next = load_clamped;
              if (load_clamped == '0) state_next = DONE;
            end
          end
        end
        RUN: begin
          // Stop outranks the wrap: the prescaler is left at its current value.
          if (sw.Stop) begin
            state_next = PAUSE;
          end else if (presc_reg == PRESC_MAX) begin
            presc_next = '0;
            tick_next  = 1'b1;
            if (dir_reg) begin
              digits_next = dec_val;
              if (dec_val == '0) state_next = DONE;
            end else begin
              digits_next = inc_val;
            end
          end else begin
            presc_next = presc_reg + PW'(1);
          end
        end
        PAUSE: begin
          if (sw.Start) state_next = RUN;
        end
        DONE: begin
          state_next = DONE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign sw.Digits  = digits_reg;
  assign sw.Tick    = tick_reg;
  assign sw.Running = (state_reg == RUN);
  assign sw.Done    = (state_reg == DONE);
  assign sw.State   = state_reg;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4, DIGITS=4.
module tb_stopwatch_ctrl;
  logic clk;
  logic rst;
  int   checks;
  int   fails;

  stopwatch_ctrl_if #(.DIGITS(4)) sw();

  stopwatch_ctrl #(.TICK_DIV(4), .DIGITS(4)) dut (
    .CLOCK_50 (clk),
    .Reset    (rst),
    .sw       (sw.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    sw.Start = 1'b1; step(); sw.Start = 1'b0;
  endtask

  task automatic pulse_clear();
    sw.Clear = 1'b1; step(); sw.Clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    checks++;
    if (sw.State !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d expected 0", sw.State); end
    checks++;
    if (sw.Digits !== 16'h0000) begin fails++; $display("FAIL reset_digits: got %h expected 0000", sw.Digits); end
    checks++;
    if ({sw.Tick, sw.Running, sw.Done} !== 3'b000) begin
      fails++; $display("FAIL reset_flags: got tick/run/done=%b expected 000", {sw.Tick, sw.Running, sw.Done});
    end
    $display("reset: state=%0d digits=%h", sw.State, sw.Digits);
  endtask

  task automatic test_up_count();
    logic exp_tick;
    sw.Down = 1'b0;
    pulse_start();
    checks++;
    if (sw.Running !== 1'b1) begin fails++; $display("FAIL up_running: got %b expected 1", sw.Running); end
    for (int i = 1; i <= 40; i++) begin
      step();
      exp_tick = (i % 4 == 0);
      checks++;
      if (sw.Tick !== exp_tick) begin
        fails++; $display("FAIL up_tick cycle %0d: got %b expected %b", i, sw.Tick, exp_tick);
      end
    end
    checks++;
    if (sw.Digits !== 16'h0010) begin fails++; $display("FAIL up_digits40: got %h expected 0010", sw.Digits); end
    checks++;
    if (sw.Running !== 1'b1) begin fails++; $display("FAIL up_running40: got %b expected 1", sw.Running); end
    $display("up_count: digits=%h running=%b", sw.Digits, sw.Running);
  endtask

  task automatic test_wrap();
    pulse_clear();
    sw.Down = 1'b0;
    pulse_start();
    step(9999 * 4);
    checks++;
    if (sw.Digits !== 16'h9999) begin fails++; $display("FAIL wrap_9999: got %h expected 9999", sw.Digits); end
    step(4);
    checks++;
    if (sw.Digits !== 16'h0000) begin fails++; $display("FAIL wrap_zero: got %h expected 0000", sw.Digits); end
    checks++;
    if (sw.State !== 2'd1 || sw.Tick !== 1'b1) begin
      fails++; $display("FAIL wrap_state: got state=%0d tick=%b expected state=1 tick=1", sw.State, sw.Tick);
    end
    $display("wrap: digits=%h state=%0d", sw.Digits, sw.State);
  endtask

  task automatic test_countdown();
    logic [15:0] exp_d [3];
    exp_d[0] = 16'h0002; exp_d[1] = 16'h0001; exp_d[2] = 16'h0000;
    pulse_clear();
    sw.Down = 1'b1;
    sw.Load = 16'h0003;
    pulse_start();
    checks++;
    if (sw.Digits !== 16'h0003 || sw.State !== 2'd1) begin
      fails++; $display("FAIL down_load: got %h/%0d expected 0003/1", sw.Digits, sw.State);
    end
    for (int t = 0; t < 3; t++) begin
      step(4);
      checks++;
      if (sw.Digits !== exp_d[t] || sw.Tick !== 1'b1) begin
        fails++; $display("FAIL down_tick%0d: got %h tick=%b expected %h tick=1", t + 1, sw.Digits, sw.Tick, exp_d[t]);
      end
    end
    checks++;
    if (sw.State !== 2'd3 || sw.Done !== 1'b1 || sw.Running !== 1'b0) begin
      fails++; $display("FAIL down_done: got state=%0d done=%b run=%b expected 3/1/0", sw.State, sw.Done, sw.Running);
    end
    for (int i = 1; i <= 20; i++) begin
      if (i == 5) sw.Start = 1'b1;
      if (i == 9) sw.Stop = 1'b1;
      step();
      sw.Start = 1'b0;
      sw.Stop  = 1'b0;
      checks++;
      if (sw.Tick !== 1'b0 || sw.State !== 2'd3) begin
        fails++; $display("FAIL done_hold cycle %0d: got tick=%b state=%0d expected 0/3", i, sw.Tick, sw.State);
      end
    end
    $display("countdown: digits=%h state=%0d", sw.Digits, sw.State);
    pulse_clear();
    checks++;
    if (sw.State !== 2'd0) begin fails++; $display("FAIL done_clear: got state=%0d expected 0", sw.State); end
  endtask

  task automatic test_pause();
    pulse_clear();
    sw.Down = 1'b0;
    pulse_start();
    step(2);
    sw.Stop = 1'b1; step(); sw.Stop = 1'b0;
    checks++;
    if (sw.State !== 2'd2) begin fails++; $display("FAIL pause_enter: got %0d expected 2", sw.State); end
    for (int i = 1; i <= 10; i++) begin
      step();
      checks++;
      if (sw.Tick !== 1'b0 || sw.Digits !== 16'h0000) begin
        fails++; $display("FAIL pause_hold cycle %0d: got tick=%b digits=%h expected 0/0000", i, sw.Tick, sw.Digits);
      end
    end
    pulse_start();
    step();
    checks++;
    if (sw.Tick !== 1'b0) begin fails++; $display("FAIL resume_early: got tick=%b expected 0", sw.Tick); end
    step();
    checks++;
    if (sw.Tick !== 1'b1 || sw.Digits !== 16'h0001) begin
      fails++; $display("FAIL resume_tick: got tick=%b digits=%h expected 1/0001", sw.Tick, sw.Digits);
    end
    // Start together with Stop while running lands in PAUSE.
    sw.Start = 1'b1; sw.Stop = 1'b1; step(); sw.Start = 1'b0; sw.Stop = 1'b0;
    checks++;
    if (sw.State !== 2'd2) begin fails++; $display("FAIL start_stop: got %0d expected 2", sw.State); end
    $display("pause: state=%0d digits=%h", sw.State, sw.Digits);
  endtask

  task automatic test_clamp();
    pulse_clear();
    sw.Down = 1'b1;
    sw.Load = 16'h00F0;
    pulse_start();
    checks++;
    if (sw.Digits !== 16'h0090) begin fails++; $display("FAIL clamp_00f0: got %h expected 0090", sw.Digits); end
    step(4);
    checks++;
    if (sw.Digits !== 16'h0089) begin fails++; $display("FAIL borrow_0089: got %h expected 0089", sw.Digits); end
    pulse_clear();
    sw.Load = 16'hFFFF;
    pulse_start();
    checks++;
    if (sw.Digits !== 16'h9999) begin fails++; $display("FAIL clamp_ffff: got %h expected 9999", sw.Digits); end
    pulse_clear();
    sw.Load = 16'h0000;
    pulse_start();
    checks++;
    if (sw.State !== 2'd3 || sw.Done !== 1'b1 || sw.Tick !== 1'b0) begin
      fails++; $display("FAIL load_zero: got state=%0d done=%b tick=%b expected 3/1/0", sw.State, sw.Done, sw.Tick);
    end
    $display("clamp: state=%0d digits=%h", sw.State, sw.Digits);
    pulse_clear();
    sw.Down = 1'b0;
    sw.Load = 16'h0000;
  endtask

  task automatic test_simultaneous();
    // Stop alone on the wrap edge: no update, prescaler holds its last value.
    pulse_start();
    step(3);
    sw.Stop = 1'b1; step(); sw.Stop = 1'b0;
    checks++;
    if (sw.State !== 2'd2 || sw.Tick !== 1'b0 || sw.Digits !== 16'h0000) begin
      fails++; $display("FAIL stop_wrap: got state=%0d tick=%b digits=%h expected 2/0/0000", sw.State, sw.Tick, sw.Digits);
    end
    pulse_start();
    step();
    checks++;
    if (sw.Tick !== 1'b1 || sw.Digits !== 16'h0001) begin
      fails++; $display("FAIL stop_wrap_resume: got tick=%b digits=%h expected 1/0001", sw.Tick, sw.Digits);
    end
    // Stop and Clear together on a wrap edge.
    step(3);
    sw.Stop = 1'b1; sw.Clear = 1'b1; step(); sw.Stop = 1'b0; sw.Clear = 1'b0;
    checks++;
    if (sw.State !== 2'd0 || sw.Digits !== 16'h0000 || sw.Tick !== 1'b0) begin
      fails++; $display("FAIL stop_clear_wrap: got state=%0d digits=%h tick=%b expected 0/0000/0", sw.State, sw.Digits, sw.Tick);
    end
    // Reset landing on a wrap edge mid-run.
    pulse_start();
    step(7);
    rst = 1'b1; step(); rst = 1'b0;
    checks++;
    if (sw.State !== 2'd0 || sw.Digits !== 16'h0000 || sw.Tick !== 1'b0 || sw.Running !== 1'b0) begin
      fails++; $display("FAIL reset_mid_run: got state=%0d digits=%h tick=%b run=%b expected 0/0000/0/0",
                        sw.State, sw.Digits, sw.Tick, sw.Running);
    end
    $display("simultaneous: state=%0d digits=%h", sw.State, sw.Digits);
  endtask

  initial begin
    checks   = 0;
    fails    = 0;
    rst      = 1'b1;
    sw.Start = 1'b0;
    sw.Stop  = 1'b0;
    sw.Clear = 1'b0;
    sw.Down  = 1'b0;
    sw.Load  = 16'h0000;
    test_reset();
    test_up_count();
    test_wrap();
    test_countdown();
    test_pause();
    test_clamp();
    test_simultaneous();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
